mem_bus_arbiter: RTL and testbench

//  Shares the single ROM/RAM memory port between two requesters: M0 (instruction fetch, read-only)
//  and M1 (data load/store). Round-robin arbitration, latched address/data, per-region wait states.

---
 rtl/mem_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one ROM/RAM port between fetch (M0) and data (M1) requesters.
// Latency: req at edge T -> ack in cycle T+W+2 (ROM write: T+1); requests wait while busy.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rom_sel,
    output logic              ram_sel,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    localparam logic [3:0] ROM_CNT = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_CNT = 4'(RAM_WAIT);

    state_t              state_q, state_d;
    logic                last_q, last_d;     // 0 = M0, 1 = M1
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

    logic                gnt_vld;
    logic                gnt_port;
    logic                gnt_we;
    logic [ADDR_W-1:0]   gnt_addr;
    logic                gnt_ram;
    logic                cur_ram;

    function automatic logic region_is_ram(input logic [1:0] msbs);
        return msbs == 2'b11;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            port_q     <= port_d;
            we_q       <= we_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Grant selection: a lone request wins; a tie goes to whoever was not served last.
    always_comb begin
        gnt_vld  = m0_req | m1_req;
        gnt_port = 1'b0;
        if (m0_req && m1_req) begin
            gnt_port = ~last_q;
        end else if (m1_req) begin
            gnt_port = 1'b1;
        end
        gnt_addr = gnt_port ? m1_addr : m0_addr;
        gnt_we   = gnt_port & m1_we;
        gnt_ram  = region_is_ram(gnt_addr[ADDR_W-1:ADDR_W-2]);
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        port_d     = port_q;
        we_d       = we_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    port_d = gnt_port;
                    last_d = gnt_port;
                    we_d   = gnt_we;
                    addr_d = gnt_addr;
                    cnt_d  = gnt_ram ? RAM_CNT : ROM_CNT;
                    if (gnt_port) begin
                        wdata_d = m1_wdata;
                    end
                    // Writes into ROM never reach the bus; they complete with an error.
                    if (gnt_we && !gnt_ram) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        if (port_q) begin
                            m1_rdata_d = mem_rdata;
                        end else begin
                            m0_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cur_ram = region_is_ram(addr_q[ADDR_W-1:ADDR_W-2]);
        rom_sel = (state_q == ST_ACCESS) & ~cur_ram;
        ram_sel = (state_q == ST_ACCESS) & cur_ram;
        mem_rd  = (state_q == ST_ACCESS) & ~we_q;
        mem_wr  = (state_q == ST_ACCESS) & we_q;
        m0_ack  = (state_q == ST_DONE) & ~port_q;
        m1_ack  = (state_q == ST_DONE) & port_q;
        m1_err  = (state_q == ST_DONE) & port_q & err_q;
        busy    = (state_q != ST_IDLE);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table of single accesses plus multi-cycle sequences.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req;
    logic [12:0] m0_addr;
    logic        m1_req;
    logic        m1_we;
    logic [12:0] m1_addr;
    logic [7:0]  m1_wdata;

    logic [7:0]  m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic        m0_ack, m1_ack, m1_err, rom_sel, ram_sel, mem_rd, mem_wr, busy;
    logic [12:0] mem_addr;

    logic [7:0]  b_m0_rdata, b_m1_rdata, b_mem_wdata;
    logic        b_m0_ack, b_m1_ack, b_m1_err, b_rom_sel, b_ram_sel, b_mem_rd, b_mem_wr, b_busy;
    logic [12:0] b_mem_addr;
    logic [7:0]  b_mem_rdata;

    int tests  = 0;
    int failed = 0;
    logic [7:0] exp_m0 = 8'h00;
    logic [7:0] exp_m1 = 8'h00;

    logic [7:0] mem [0:8191];

    mem_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rom_sel(rom_sel), .ram_sel(ram_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy)
    );

    mem_bus_arbiter #(.RAM_WAIT(3)) dut_w3 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack), .m1_err(b_m1_err),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .rom_sel(b_rom_sel), .ram_sel(b_ram_sel), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: ROM/RAM pattern i[7:0]^0x96 with two fixed cells; RAM writes land on the edge.
    initial begin
        for (int i = 0; i < 8192; i++) begin
            logic [12:0] a;
            a = 13'(i);
            mem[i] = a[7:0] ^ 8'h96;
        end
        mem[13'h0040] = 8'hA5;
        mem[13'h1FFF] = 8'hE7;
        forever begin
            @(posedge clk);
            if (ram_sel && mem_wr) mem[mem_addr] = mem_wdata;
        end
    end

    assign mem_rdata   = mem[mem_addr];
    assign b_mem_rdata = 8'h77;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string what, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", what, act, exp);
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        bit          rom;
        int          lat;
        int          strobes;
        logic [7:0]  rdata;
        bit          err;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int idx, input vec_t v);
        int n, strobes, sel_bad, wrong_ack;
        bit acked, err_seen;
        logic [7:0] rd;
        n = 0; strobes = 0; sel_bad = 0; wrong_ack = 0; acked = 0; err_seen = 0; rd = 8'h00;
        @(negedge clk);
        if (!v.port) begin
            m0_req = 1'b1; m0_addr = v.addr;
        end else begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end
        while (!acked && n < 40) begin
            @(negedge clk);
            n++;
            if (mem_rd || mem_wr) begin
                strobes++;
                if (rom_sel != v.rom || ram_sel != !v.rom) sel_bad++;
                if (mem_wr != v.we || mem_rd != !v.we) sel_bad++;
                if (mem_addr != v.addr) sel_bad++;
                if (v.we && mem_wdata != v.wdata) sel_bad++;
            end else if (rom_sel || ram_sel) begin
                sel_bad++;
            end
            if (m1_err && !m1_ack) sel_bad++;
            if ((v.port ? m0_ack : m1_ack)) wrong_ack++;
            if ((v.port ? m1_ack : m0_ack)) begin
                acked    = 1;
                err_seen = m1_err;
                rd       = v.port ? m1_rdata : m0_rdata;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        if (!v.we) begin
            if (v.port) exp_m1 = v.rdata; else exp_m0 = v.rdata;
        end
        check($sformatf("vec%0d ack latency", idx), n, v.lat);
        check($sformatf("vec%0d strobe cycles", idx), strobes, v.strobes);
        check($sformatf("vec%0d select/strobe/bus errors", idx), sel_bad, 0);
        check($sformatf("vec%0d ack on wrong port", idx), wrong_ack, 0);
        check($sformatf("vec%0d m1_err", idx), int'(err_seen), int'(v.err));
        if (!v.we) check($sformatf("vec%0d rdata", idx), rd, v.rdata);
        @(negedge clk);
        check($sformatf("vec%0d ack/busy after done", idx), {m0_ack, m1_ack, busy}, 0);
        check($sformatf("vec%0d m0_rdata held", idx), m0_rdata, exp_m0);
        check($sformatf("vec%0d m1_rdata held", idx), m1_rdata, exp_m1);
    endtask

    initial begin
        int n, first, second, acks, ackcnt, strobes;
        int order [4];

        vecs[0] = '{0, 0, 13'h0040, 8'h00, 1, 3, 2, 8'hA5, 0};
        vecs[1] = '{1, 1, 13'h1801, 8'h3C, 0, 2, 1, 8'h00, 0};
        vecs[2] = '{1, 0, 13'h1801, 8'h00, 0, 2, 1, 8'h3C, 0};
        vecs[3] = '{1, 1, 13'h0100, 8'hEE, 1, 1, 0, 8'h00, 1};
        vecs[4] = '{1, 0, 13'h17FF, 8'h00, 1, 3, 2, 8'h69, 0};
        vecs[5] = '{1, 0, 13'h1800, 8'h00, 0, 2, 1, 8'h96, 0};
        vecs[6] = '{0, 0, 13'h1FFF, 8'h00, 0, 2, 1, 8'hE7, 0};

        rst_n = 1'b0; m0_req = 1'b0; m0_addr = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset control outputs",
              {m0_ack, m1_ack, m1_err, rom_sel, ram_sel, mem_rd, mem_wr, busy}, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset rdata", {m0_rdata, m1_rdata, mem_wdata}, 0);
        rst_n = 1'b1;

        // Both requesters from reset: M0 first, then strict alternation while both hold.
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 13'h0020;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 13'h1810;
        acks = 0; n = 0;
        while (acks < 4 && n < 80) begin
            @(negedge clk);
            n++;
            if (m0_ack) begin order[acks] = 0; acks++; end
            else if (m1_ack) begin order[acks] = 1; acks++; end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("rr ack count", acks, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < acks) check($sformatf("rr grant %0d port", k), order[k], k % 2);
        end
        exp_m0 = 8'hB6; exp_m1 = 8'h86;
        check("rr m0_rdata", m0_rdata, 8'hB6);
        check("rr m1_rdata", m1_rdata, 8'h86);
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // M0 drops req right after the grant edge; the access still completes.
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 13'h0041;
        @(negedge clk);
        m0_req = 1'b0;
        n = 1;
        while (!m0_ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        exp_m0 = 8'hD7;
        check("dropped req ack latency", n, 3);
        check("dropped req rdata", m0_rdata, 8'hD7);

        // One port held continuously: one ROM access every ROM_WAIT+3 cycles.
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 13'h0050;
        n = 0; first = -1; second = -1;
        while (second < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (m0_ack) begin
                if (first < 0) first = n; else second = n;
            end
        end
        m0_req = 1'b0;
        exp_m0 = 8'hC6;
        check("back-to-back first ack", first, 3);
        check("back-to-back spacing", second - first, 4);
        check("back-to-back rdata", m0_rdata, 8'hC6);

        // Reset in the middle of a long RAM write on the RAM_WAIT=3 instance.
        repeat (10) @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 13'h1900; m1_wdata = 8'h55;
        repeat (2) @(negedge clk);
        check("w3 mid-access strobe", {b_ram_sel, b_rom_sel, b_mem_wr, b_mem_rd, b_busy}, 5'b10101);
        check("w3 mid-access wdata", b_mem_wdata, 8'h55);
        #2 rst_n = 1'b0;
        #1;
        check("w3 async reset outputs",
              {b_m0_ack, b_m1_ack, b_m1_err, b_rom_sel, b_ram_sel, b_mem_rd, b_mem_wr, b_busy}, 0);
        check("w3 async reset regs", {b_mem_addr, b_mem_wdata, b_m0_rdata, b_m1_rdata}, 0);
        m1_req = 1'b0; m1_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ackcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (b_m1_ack || b_busy) ackcnt++;
        end
        check("w3 dropped access silent", ackcnt, 0);

        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 13'h1801;
        n = 0; strobes = 0;
        while (!b_m1_ack && n < 40) begin
            @(negedge clk);
            n++;
            if (b_mem_rd && b_ram_sel) strobes++;
        end
        m1_req = 1'b0;
        check("w3 post-reset latency", n, 5);
        check("w3 post-reset strobes", strobes, 4);
        check("w3 post-reset rdata", b_m1_rdata, 8'h77);
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
